// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock. Round keys are fetched by index
// from an external key store, so one datapath covers AES-128/192/256.
module aes_inv_cipher_iter #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt_out
);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NrIdx  = 4'(NR);
  localparam logic [3:0] NrLast = 4'(NR - 1);

  // Inverse S-box, entry b at InvSbox[b].
  localparam logic [0:255][7:0] InvSbox = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
  endfunction

  // One column of InvMixColumns; the 09/0b/0d/0e multiples are built from a xtime chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a     = col[31-8*i -: 8];
      x2    = xtime(a);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  typedef enum logic [1:0] {StIdle, StRound, StDone} st_e;

  st_e          st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [127:0] pt_q, pt_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] isr, isb, rnd_t, imc;

  always_comb begin
    isr   = '0;
    isb   = '0;
    imc   = '0;
    // Byte k = 4*col + row; row r rotates right by r.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr[127-8*(4*c+r) -: 8] = state_q[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) begin
      isb[127-8*i -: 8] = InvSbox[isr[127-8*i -: 8]];
    end
    rnd_t = isb ^ rk_data;
    for (int c = 0; c < 4; c++) begin
      imc[127-32*c -: 32] = inv_mix_col(rnd_t[127-32*c -: 32]);
    end
  end

  always_comb begin
    st_d      = st_q;
    state_d   = state_q;
    rnd_d     = rnd_q;
    pt_d      = pt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = '0;
    unique case (st_q)
      StIdle: begin
        in_ready = 1'b1;
        rk_idx   = NrIdx;
        if (in_valid) begin
          state_d = ct_in ^ rk_data;
          rnd_d   = NrLast;
          st_d    = StRound;
        end
      end
      StRound: begin
        rk_idx = rnd_q;
        if (rnd_q != 4'd0) begin
          state_d = imc;
          rnd_d   = rnd_q - 4'd1;
        end else begin
          pt_d = rnd_t;
          st_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          st_d = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= StIdle;
      state_q <= '0;
      rnd_q   <= '0;
      pt_q    <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
      pt_q    <= pt_d;
    end
  end

  assign pt_out = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: an AES-128 and an AES-256 instance checked every cycle against
// a forward-cipher reference model that supplies round keys and expected plaintexts.
module tb_aes_inv_cipher_iter;

  localparam int unsigned NR0 = 10;
  localparam int unsigned NR1 = 14;
  localparam int unsigned Nrs [2] = '{NR0, NR1};

  localparam logic [127:0] V_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] V1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] V3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] V3_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [127:0] ct_in     [2];
  logic [3:0]   rk_idx    [2];
  logic [127:0] rk_data   [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [127:0] pt_out    [2];

  aes_inv_cipher_iter #(.NR(NR0)) u_dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .ct_in(ct_in[0]),
    .rk_idx(rk_idx[0]), .rk_data(rk_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .pt_out(pt_out[0])
  );

  aes_inv_cipher_iter #(.NR(NR1)) u_dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .ct_in(ct_in[1]),
    .rk_idx(rk_idx[1]), .rk_data(rk_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .pt_out(pt_out[1])
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Model state per instance: 0 idle, 1 busy (m_cnt rounds done), 2 holding result.
  int           m_st  [2];
  int           m_cnt [2];
  logic [127:0] m_pt  [2];
  logic [127:0] m_exp [2];
  logic [127:0] nxt_rk [2][16];
  logic [127:0] act_rk [2][16];
  logic [127:0] exp_q0 [$];
  logic [127:0] exp_q1 [$];
  logic [127:0] tmp_rk [16];
  logic [7:0]   sbox [256];

  bit or_rand  [2];
  bit or_force [2];
  bit or_bit   [2];

  // Key store serves the queued key while idle and the in-flight block's key otherwise.
  assign rk_data[0]   = (m_st[0] == 0) ? nxt_rk[0][rk_idx[0]] : act_rk[0][rk_idx[0]];
  assign rk_data[1]   = (m_st[1] == 0) ? nxt_rk[1][rk_idx[1]] : act_rk[1][rk_idx[1]];
  assign out_ready[0] = or_rand[0] ? or_bit[0] : or_force[0];
  assign out_ready[1] = or_rand[1] ? or_bit[1] : or_force[1];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) or_bit[d] = 1'($urandom_range(0, 1));
  end

  function automatic void chk(input int d, input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL d%0d %s: got %h want %h", d, name, act, exp);
    end
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box from its definition: multiplicative inverse then affine map.
  function automatic void build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
                {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic void expand(input logic [255:0] key, input int nr);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rcon;
    int          nk;
    nk   = nr - 6;
    rcon = 8'h01;
    for (int i = 0; i < 64; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gm(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) tmp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ tmp_rk[0][127-8*i -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) u[4*c+r] = sbox[s[4*((c+r)%4)+r]];
      if (rd != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
          u[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          u[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          u[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          u[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = u[i] ^ tmp_rk[rd][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] pop_exp(input int d);
    logic [127:0] v;
    v = '0;
    checks++;
    if (d == 0 && exp_q0.size() > 0) v = exp_q0.pop_front();
    else if (d == 1 && exp_q1.size() > 0) v = exp_q1.pop_front();
    else begin
      errors++;
      $display("FAIL d%0d accept: got a block accepted, want none queued", d);
    end
    return v;
  endfunction

  // Protocol/latency model: accept in idle, result visible NR+1 cycles after accept.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_st[d]  <= 0;
        m_cnt[d] <= 0;
        m_pt[d]  <= '0;
      end else begin
        case (m_st[d])
          0: if (in_valid[d]) begin
            for (int k = 0; k < 16; k++) act_rk[d][k] <= nxt_rk[d][k];
            m_exp[d] <= pop_exp(d);
            m_st[d]  <= 1;
            m_cnt[d] <= 0;
          end
          1: begin
            m_cnt[d] <= m_cnt[d] + 1;
            if (m_cnt[d] + 1 == int'(Nrs[d])) begin
              m_st[d] <= 2;
              m_pt[d] <= m_exp[d];
            end
          end
          2: if (out_ready[d]) m_st[d] <= 0;
          default: m_st[d] <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [3:0] eidx;
        eidx = (m_st[d] == 0) ? 4'(Nrs[d]) : (m_st[d] == 1) ? 4'(int'(Nrs[d]) - 1 - m_cnt[d]) : 4'd0;
        chk(d, "in_ready", 128'(in_ready[d]), 128'(m_st[d] == 0));
        chk(d, "out_valid", 128'(out_valid[d]), 128'(m_st[d] == 2));
        chk(d, "rk_idx", 128'(rk_idx[d]), 128'(eidx));
        chk(d, "pt_out", pt_out[d], m_pt[d]);
      end
    end
  end

  task automatic load_key(input int d, input logic [255:0] key);
    expand(key, int'(Nrs[d]));
    for (int k = 0; k < 16; k++) nxt_rk[d][k] = tmp_rk[k];
  endtask

  // Present a block and return at the falling edge just after it is accepted (cycle 1).
  task automatic send(input int d, input logic [127:0] ct, input logic [127:0] pt);
    int n;
    n = 0;
    if (d == 0) exp_q0.push_back(pt);
    else exp_q1.push_back(pt);
    ct_in[d]    = ct;
    in_valid[d] = 1'b1;
    while (m_st[d] != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(d, "accept_timeout", 128'(n >= 300), 128'(0));
    @(negedge clk);
  endtask

  task automatic wait_out(input int d, output int lat);
    lat = 1;
    while (!out_valid[d] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while ((m_st[d] != 0 || (d == 0 ? exp_q0.size() : exp_q1.size()) != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(d, "drain_timeout", 128'(n >= 400), 128'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want finish before 400us");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [255:0] key;
    logic [127:0] pt, ct;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      ct_in[d]    = '0;
      or_rand[d]  = 1'b0;
      or_force[d] = 1'b1;
      for (int k = 0; k < 16; k++) begin
        nxt_rk[d][k] = '0;
        act_rk[d][k] = '0;
      end
    end
    build_sbox();

    // Pin the reference model to published values.
    chk(0, "model sbox[00]", 128'(sbox[0]), 128'(8'h63));
    chk(0, "model sbox[53]", 128'(sbox[8'h53]), 128'(8'hed));
    expand(V1_KEY, 10);
    chk(0, "model rk10", tmp_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk(0, "model enc128", encrypt(V_PT, 10), V1_CT);
    expand(V3_KEY, 14);
    chk(1, "model enc256", encrypt(V_PT, 14), V3_CT);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    cmp_en = 1'b1;
    chk(0, "reset in_ready", 128'(in_ready[0]), 128'(1));
    chk(0, "reset out_valid", 128'(out_valid[0]), 128'(0));
    chk(0, "reset pt_out", pt_out[0], 128'h0);
    chk(0, "idle rk_idx", 128'(rk_idx[0]), 128'(10));
    chk(1, "idle rk_idx", 128'(rk_idx[1]), 128'(14));

    // AES-128 vector with rk_idx sequence and in_ready trace.
    load_key(0, V1_KEY);
    send(0, V1_CT, V_PT);
    in_valid[0] = 1'b0;
    lat = 1;
    while (!out_valid[0] && lat < 40) begin
      chk(0, "v1 rk_idx", 128'(rk_idx[0]), 128'(NR0 - 32'(lat)));
      chk(0, "v1 in_ready busy", 128'(in_ready[0]), 128'(0));
      @(negedge clk);
      lat++;
    end
    chk(0, "v1 latency", 128'(lat), 128'(11));
    chk(0, "v1 pt", pt_out[0], V_PT);
    chk(0, "v1 in_ready done", 128'(in_ready[0]), 128'(0));
    @(negedge clk);
    chk(0, "v1 in_ready after", 128'(in_ready[0]), 128'(1));

    // AES-256 vector.
    load_key(1, V3_KEY);
    send(1, V3_CT, V_PT);
    in_valid[1] = 1'b0;
    wait_out(1, lat);
    chk(1, "v3 latency", 128'(lat), 128'(15));
    chk(1, "v3 pt", pt_out[1], V_PT);
    @(negedge clk);

    // Stall in DONE with stray in_valid pulses; result must hold.
    or_force[0] = 1'b0;
    send(0, V1_CT, V_PT);
    ct_in[0] = 128'hdeadbeef_00000000_cafef00d_12345678;
    lat = 0;
    while (!out_valid[0] && lat < 40) begin
      in_valid[0] = 1'(lat % 2);
      @(negedge clk);
      lat++;
    end
    for (int i = 0; i < 20; i++) begin
      in_valid[0] = (i < 10) && (i % 2 == 0);
      chk(0, "stall pt", pt_out[0], V_PT);
      chk(0, "stall out_valid", 128'(out_valid[0]), 128'(1));
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    or_force[0] = 1'b1;
    @(negedge clk);
    or_force[0] = 1'b0;
    chk(0, "stall in_ready after", 128'(in_ready[0]), 128'(1));
    chk(0, "stall out_valid after", 128'(out_valid[0]), 128'(0));
    or_force[0] = 1'b1;

    // Reset mid-round, then re-issue the same block.
    send(0, V1_CT, V_PT);
    in_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk(0, "rst in_ready", 128'(in_ready[0]), 128'(1));
    chk(0, "rst out_valid", 128'(out_valid[0]), 128'(0));
    chk(0, "rst pt_out", pt_out[0], 128'h0);
    send(0, V1_CT, V_PT);
    in_valid[0] = 1'b0;
    wait_out(0, lat);
    chk(0, "rerun latency", 128'(lat), 128'(11));
    chk(0, "rerun pt", pt_out[0], V_PT);
    @(negedge clk);

    // Back-to-back random traffic, in_valid held high, random back-pressure.
    for (int d = 0; d < 2; d++) begin
      or_rand[d] = 1'b1;
      for (int n = 0; n < (d == 0 ? 100 : 10); n++) begin
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (d == 0) key[127:0] = '0;
        load_key(d, key);
        pt = {$urandom, $urandom, $urandom, $urandom};
        ct = encrypt(pt, int'(Nrs[d]));
        send(d, ct, pt);
      end
      in_valid[d] = 1'b0;
      or_rand[d]  = 1'b0;
      drain(d);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
